// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - parametrised PC / fetch sequencer with branch, stall, halt, single-step and counters
module fetch_sequencer #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  PC_STEP     = 1,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [6:0]          HALT_OPCODE = 7'b1111111,
    parameter int                  CNT_WIDTH   = 32
) (
    input  logic                 clk_1,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 step_mode,
    input  logic                 step_req,
    input  logic                 resume,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 fire,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        STEP = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] STEP_INC   = PC_WIDTH'(PC_STEP);
    // Byte-addressed fetch keeps branch targets word aligned.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = (PC_STEP == 4) ? ~PC_WIDTH'(3) : '1;

    state_t              state;
    logic                is_halt;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] branch_pc;
    logic                unused_instr_bits;

    assign is_halt           = (instr[6:0] == HALT_OPCODE);
    assign pc_inc            = pc + STEP_INC;
    assign branch_pc         = branch_target & ALIGN_MASK;
    assign unused_instr_bits = ^instr[31:7];

    assign fire = !is_halt && !stall &&
                  (((state == RUN) && !step_mode) ||
                   ((state == STEP) && step_mode && step_req));

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state != HALT) begin
                cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            end

            // fire is never true in HALT or on a mode-transition cycle.
            if (fire) begin
                pc <= branch_taken ? branch_pc : pc_inc;
                if (retired_cnt != '1) begin
                    retired_cnt <= retired_cnt + CNT_WIDTH'(1);
                end
            end

            case (state)
                RUN: begin
                    if (is_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (step_mode) begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (is_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (!step_mode) begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    // Resume skips past the halt instruction itself.
                    if (resume) begin
                        pc     <= pc_inc;
                        state  <= step_mode ? STEP : RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer against a behavioural model
module tb_fetch_sequencer;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HLT  = 32'h0000_007F;
    localparam int          MRUN = 0;
    localparam int          MSTP = 1;
    localparam int          MHLT = 2;

    logic        clk_1 = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = NOP;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        step_mode = 1'b0;
    logic        step_req = 1'b0;
    logic        resume = 1'b0;

    logic [7:0]  pc_a, pc_b;
    logic        fire_a, fire_b, halted_a, halted_b;
    logic [31:0] cyc_a, ret_a;
    logic [3:0]  cyc_b, ret_b;

    int checks = 0;
    int failures = 0;

    // Model state, index 0 = word-addressed DUT, 1 = byte-addressed DUT with 4-bit counters
    int              m_mode[2];
    logic [7:0]      m_pc[2];
    longint unsigned m_cyc[2];
    longint unsigned m_ret[2];
    bit              m_valid = 0;

    int              p_step[2]  = '{1, 4};
    logic [7:0]      p_reset[2] = '{8'h10, 8'h08};
    longint unsigned p_cmod[2]  = '{64'h1_0000_0000, 64'd16};

    always #5 clk_1 = ~clk_1;

    fetch_sequencer #(
        .PC_WIDTH(8), .PC_STEP(1), .RESET_PC(8'h10), .HALT_OPCODE(7'h7F), .CNT_WIDTH(32)
    ) dut_a (
        .clk_1(clk_1), .rst(rst), .instr(instr), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .step_mode(step_mode), .step_req(step_req), .resume(resume),
        .pc(pc_a), .fire(fire_a), .halted(halted_a),
        .cycle_cnt(cyc_a), .retired_cnt(ret_a)
    );

    fetch_sequencer #(
        .PC_WIDTH(8), .PC_STEP(4), .RESET_PC(8'h08), .HALT_OPCODE(7'h7F), .CNT_WIDTH(4)
    ) dut_b (
        .clk_1(clk_1), .rst(rst), .instr(instr), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .step_mode(step_mode), .step_req(step_req), .resume(resume),
        .pc(pc_b), .fire(fire_b), .halted(halted_b),
        .cycle_cnt(cyc_b), .retired_cnt(ret_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_fire(input int i);
        bit hlt;
        hlt = (instr[6:0] == 7'h7F);
        return !hlt && !stall &&
               ((m_mode[i] == MRUN && !step_mode) ||
                (m_mode[i] == MSTP && step_mode && step_req));
    endfunction

    task automatic model_update(input int i);
        bit f;
        f = model_fire(i);
        if (rst) begin
            m_pc[i] = p_reset[i]; m_mode[i] = MRUN; m_cyc[i] = 0; m_ret[i] = 0;
        end else begin
            if (m_mode[i] != MHLT) m_cyc[i] = (m_cyc[i] + 1) % p_cmod[i];
            if (m_mode[i] == MHLT) begin
                if (resume) begin
                    m_pc[i]   = 8'((int'(m_pc[i]) + p_step[i]) % 256);
                    m_mode[i] = step_mode ? MSTP : MRUN;
                end
            end else if (instr[6:0] == 7'h7F) begin
                m_mode[i] = MHLT;
            end else if (m_mode[i] == MRUN && step_mode) begin
                m_mode[i] = MSTP;
            end else if (m_mode[i] == MSTP && !step_mode) begin
                m_mode[i] = MRUN;
            end else if (f) begin
                if (branch_taken)
                    m_pc[i] = (p_step[i] == 4) ? (branch_target & 8'hFC) : branch_target;
                else
                    m_pc[i] = 8'((int'(m_pc[i]) + p_step[i]) % 256);
                if (m_ret[i] < p_cmod[i] - 1) m_ret[i] = m_ret[i] + 1;
            end
        end
    endtask

    task automatic tick(input logic r, input logic [31:0] ins, input logic st, input logic br,
                        input logic [7:0] tgt, input logic sm, input logic sr, input logic rs);
        rst = r; instr = ins; stall = st; branch_taken = br; branch_target = tgt;
        step_mode = sm; step_req = sr; resume = rs;
        #1;
        if (m_valid) begin
            check("a_pc",     64'(pc_a),     64'(m_pc[0]));
            check("a_fire",   64'(fire_a),   64'(model_fire(0)));
            check("a_halted", 64'(halted_a), 64'(m_mode[0] == MHLT));
            check("a_cycle",  64'(cyc_a),    m_cyc[0]);
            check("a_retired",64'(ret_a),    m_ret[0]);
            check("b_pc",     64'(pc_b),     64'(m_pc[1]));
            check("b_fire",   64'(fire_b),   64'(model_fire(1)));
            check("b_halted", 64'(halted_b), 64'(m_mode[1] == MHLT));
            check("b_cycle",  64'(cyc_b),    m_cyc[1]);
            check("b_retired",64'(ret_b),    m_ret[1]);
        end
        @(posedge clk_1);
        model_update(0);
        model_update(1);
        if (r) m_valid = 1;
        @(negedge clk_1);
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) tick(0, NOP, 0, 0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        logic [7:0]  pc_before;
        logic [31:0] ins;
        logic        sm;
        @(negedge clk_1);

        // Reset and straight-line fetch
        tick(1, NOP, 0, 0, 8'h00, 0, 0, 0);
        check("reset_pc_a", 64'(pc_a), 64'h10);
        check("reset_pc_b", 64'(pc_b), 64'h08);
        check("reset_halted", 64'(halted_a), 64'h0);
        check("reset_cycle", 64'(cyc_a), 64'h0);
        nop(3);
        check("seq_pc_a", 64'(pc_a), 64'h13);
        check("seq_retired_a", 64'(ret_a), 64'd3);
        check("seq_pc_b", 64'(pc_b), 64'h14);

        // Branch with alignment; stall takes priority over branch
        tick(1, NOP, 0, 0, 8'h00, 0, 0, 0);
        tick(0, NOP, 1, 1, 8'h23, 0, 0, 0);
        check("stall_pc_b", 64'(pc_b), 64'h08);
        tick(0, NOP, 0, 1, 8'h23, 0, 0, 0);
        check("branch_pc_b", 64'(pc_b), 64'h20);
        check("branch_pc_a", 64'(pc_a), 64'h23);

        // Wrap-around past the top of the address space
        tick(0, NOP, 0, 1, 8'hFE, 0, 0, 0);
        nop(1);
        check("wrap_pc_b", 64'(pc_b), 64'h00);
        nop(1);
        check("wrap_pc_a", 64'(pc_a), 64'h00);

        // Halt: pc and counters frozen, other controls ignored, resume skips the halt
        tick(1, NOP, 0, 0, 8'h00, 0, 0, 0);
        nop(2);
        tick(0, HLT, 0, 0, 8'h00, 0, 0, 0);
        check("halt_entry", 64'(halted_a), 64'h1);
        for (int k = 0; k < 10; k++) tick(0, NOP, k[0], 1, 8'h40, 0, 1, 0);
        check("halt_pc_a", 64'(pc_a), 64'h12);
        check("halt_cycle_a", 64'(cyc_a), 64'd3);
        tick(0, NOP, 0, 0, 8'h00, 0, 0, 1);
        check("resume_pc_a", 64'(pc_a), 64'h13);
        check("resume_halted", 64'(halted_a), 64'h0);
        check("resume_retired_a", 64'(ret_a), 64'd2);

        // Single-step: three spaced pulses give three advances; stalled request gives none
        tick(0, NOP, 0, 0, 8'h00, 1, 0, 0);
        pc_before = pc_a;
        for (int k = 0; k < 3; k++) begin
            tick(0, NOP, 0, 0, 8'h00, 1, 1, 0);
            for (int j = 0; j < 3; j++) tick(0, NOP, 0, 0, 8'h00, 1, 0, 0);
        end
        check("step_advances", 64'(pc_a), 64'(8'(pc_before + 8'd3)));
        tick(0, NOP, 1, 0, 8'h00, 1, 1, 0);
        check("step_stalled", 64'(pc_a), 64'(8'(pc_before + 8'd3)));

        // Reset from STEP and from HALT
        tick(1, NOP, 0, 0, 8'h00, 1, 0, 0);
        check("rst_step_pc", 64'(pc_a), 64'h10);
        check("rst_step_ret", 64'(ret_a), 64'h0);
        tick(0, HLT, 0, 0, 8'h00, 1, 0, 0);
        tick(1, NOP, 0, 0, 8'h00, 0, 0, 0);
        check("rst_halt_halted", 64'(halted_a), 64'h0);
        check("rst_halt_pc_b", 64'(pc_b), 64'h08);
        check("rst_halt_cycle_b", 64'(cyc_b), 64'h0);

        // Randomized run, with long stretches free of reset so narrow counters saturate/wrap
        sm = 0;
        for (int k = 0; k < 3000; k++) begin
            ins = $urandom;
            if (ins[6:0] == 7'h7F) ins[0] = 1'b0;
            if ($urandom_range(0, 99) < 5) ins[6:0] = 7'h7F;
            if ($urandom_range(0, 99) < 3) sm = ~sm;
            tick(($urandom_range(0, 999) < 3), ins,
                 ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 20),
                 8'($urandom), sm, ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < 25));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
